// File: rtl/joypad_scanner_if.sv
// Signal bundle between the joypad scanner and the host/pad side.
// The scanner uses the slave modport; the host or pad model uses master.
interface joypad_scanner_if #(
    parameter int NUM_PADS = 2
);
    logic                     enable;
    logic                     poll_req;
    logic [NUM_PADS-1:0]      data;
    logic                     latch;
    logic                     sclk;
    logic [12*NUM_PADS-1:0]   buttons;
    logic [12*NUM_PADS-1:0]   pressed;
    logic [12*NUM_PADS-1:0]   released;
    logic [NUM_PADS-1:0]      present;
    logic                     frame_valid;

    modport master (
        output enable, poll_req, data,
        input  latch, sclk, buttons, pressed, released, present, frame_valid
    );

    modport slave (
        input  enable, poll_req, data,
        output latch, sclk, buttons, pressed, released, present, frame_valid
    );
endinterface

// File: rtl/joypad_scanner.sv
// Serial joypad scanner: periodically latches up to four pads, shifts 17 bits
// from each in parallel and publishes debounced-free button state plus edge events.
module joypad_scanner #(
    parameter int NUM_PADS  = 2,
    parameter int POLL_DIV  = 1372,
    parameter int HALF_BIT  = 1,
    parameter int LATCH_LEN = 2
) (
    input  logic            clk,
    input  logic            res,
    joypad_scanner_if.slave bus
);
    localparam int NB     = 12 * NUM_PADS;
    localparam int CNT_W  = $clog2(POLL_DIV);
    localparam int PH_MAX = (LATCH_LEN > HALF_BIT) ? LATCH_LEN : HALF_BIT;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_LOW    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_poll_cnt;
    logic [PH_W-1:0]          r_phase;
    logic [4:0]               r_bit_idx;
    logic                     r_pending;
    logic [NUM_PADS-1:0][12:0] r_keep;
    logic                     r_latch;
    logic                     r_sclk;
    logic                     r_frame_valid;
    logic [NB-1:0]            r_buttons;
    logic [NB-1:0]            r_pressed;
    logic [NB-1:0]            r_released;
    logic [NUM_PADS-1:0]      r_present;

    logic                     w_poll_hit;
    logic                     w_start;
    logic                     w_latch_done;
    logic                     w_half_done;
    logic                     w_latch_nxt;
    logic                     w_sclk_nxt;
    logic                     w_commit_nxt;
    logic [NB-1:0]            w_new_buttons;
    logic [NUM_PADS-1:0]      w_new_present;

    // keep[11:0] holds serial bits 0..11 already inverted, keep[12] the raw bit 16.
    function automatic logic [11:0] map_pad(input logic [12:0] keep);
        logic [11:0] mapped;
        mapped = {keep[3], keep[2], keep[11], keep[10], keep[1], keep[9],
                  keep[0], keep[8], keep[7], keep[6], keep[5], keep[4]};
        return keep[12] ? 12'd0 : mapped;
    endfunction

    assign w_poll_hit   = (r_poll_cnt == CNT_W'(POLL_DIV - 1));
    assign w_start      = bus.enable && (w_poll_hit || bus.poll_req || r_pending);
    assign w_latch_done = (r_phase == PH_W'(LATCH_LEN - 1));
    assign w_half_done  = (r_phase == PH_W'(HALF_BIT - 1));

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_LATCH;
                else         w_state_nxt = ST_IDLE;
            end
            ST_LATCH: begin
                if (w_latch_done) w_state_nxt = ST_LOW;
                else              w_state_nxt = ST_LATCH;
            end
            ST_LOW: begin
                if (w_half_done) w_state_nxt = ST_HIGH;
                else             w_state_nxt = ST_LOW;
            end
            ST_HIGH: begin
                if (w_half_done && (r_bit_idx == 5'd16)) w_state_nxt = ST_COMMIT;
                else if (w_half_done)                    w_state_nxt = ST_LOW;
                else                                     w_state_nxt = ST_HIGH;
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: pins are registered from the upcoming state so they align with it.
    always_comb begin
        w_latch_nxt   = (w_state_nxt == ST_LATCH);
        w_sclk_nxt    = (w_state_nxt != ST_LOW);
        w_commit_nxt  = (w_state_nxt == ST_COMMIT);
        w_new_buttons = '0;
        w_new_present = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            w_new_buttons[12*p +: 12] = map_pad(r_keep[p]);
            w_new_present[p]          = ~r_keep[p][12];
        end
    end

    // Poll divider and the single-entry request latch.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_poll_cnt <= '0;
            r_pending  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (!bus.enable || w_start) begin
                r_poll_cnt <= '0;
                r_pending  <= 1'b0;
            end else begin
                r_poll_cnt <= r_poll_cnt + CNT_W'(1'b1);
                r_pending  <= r_pending;
            end
        end else begin
            r_poll_cnt <= '0;
            r_pending  <= r_pending | bus.poll_req;
        end
    end

    // Half-period timer and serial bit index.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_phase   <= '0;
            r_bit_idx <= 5'd0;
        end else begin
            if (w_state_nxt != r_state) r_phase <= '0;
            else                        r_phase <= r_phase + PH_W'(1'b1);
            if (r_state == ST_LATCH)                    r_bit_idx <= 5'd0;
            else if ((r_state == ST_HIGH) && w_half_done) r_bit_idx <= r_bit_idx + 5'd1;
            else                                        r_bit_idx <= r_bit_idx;
        end
    end

    // Sample every pad at the end of each LOW half-period; serial bits 12-15 are dropped.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_keep <= '0;
        end else if ((r_state == ST_LOW) && w_half_done) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (r_bit_idx < 5'd12)        r_keep[p][r_bit_idx[3:0]] <= ~bus.data[p];
                else if (r_bit_idx == 5'd16)  r_keep[p][12] <= bus.data[p];
                else                          r_keep[p] <= r_keep[p];
            end
        end else begin
            r_keep <= r_keep;
        end
    end

    // Registered pins and the per-frame publish with edge events.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_latch       <= 1'b0;
            r_sclk        <= 1'b1;
            r_frame_valid <= 1'b0;
            r_buttons     <= '0;
            r_pressed     <= '0;
            r_released    <= '0;
            r_present     <= '0;
        end else begin
            r_latch       <= w_latch_nxt;
            r_sclk        <= w_sclk_nxt;
            r_frame_valid <= w_commit_nxt;
            if (w_commit_nxt) begin
                r_buttons  <= w_new_buttons;
                r_present  <= w_new_present;
                r_pressed  <= w_new_buttons & ~r_buttons;
                r_released <= r_buttons & ~w_new_buttons;
            end else begin
                r_buttons  <= r_buttons;
                r_present  <= r_present;
                r_pressed  <= '0;
                r_released <= '0;
            end
        end
    end

    assign bus.latch       = r_latch;
    assign bus.sclk        = r_sclk;
    assign bus.frame_valid = r_frame_valid;
    assign bus.buttons     = r_buttons;
    assign bus.pressed     = r_pressed;
    assign bus.released    = r_released;
    assign bus.present     = r_present;
endmodule

// File: tb/tb_joypad_scanner.sv
// Bench for joypad_scanner: pad shift-register models, a frame-position reference
// model compared every cycle, and directed literal checks of timing and events.
module tb_joypad_scanner;
    localparam int NP = 2;
    localparam int PD = 40;
    localparam int HB = 3;
    localparam int LL = 4;
    localparam int FL = LL + 34 * HB + 1;
    localparam int SMAP [12] = '{4, 5, 6, 7, 8, 0, 9, 1, 10, 11, 2, 3};

    logic clk = 1'b0;
    logic res = 1'b0;
    joypad_scanner_if #(.NUM_PADS(NP)) bus ();

    joypad_scanner #(
        .NUM_PADS(NP), .POLL_DIV(PD), .HALF_BIT(HB), .LATCH_LEN(LL)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [11:0] model_pad(input logic [16:0] line);
        logic [11:0] r;
        r = '0;
        if (line[16] == 1'b0) begin
            for (int i = 0; i < 12; i++) r[i] = ~line[SMAP[i]];
        end
        return r;
    endfunction

    // Pad models: load on latch, advance on each sclk rising edge.
    logic [16:0] pad_line [NP];
    logic [16:0] sent [NP];
    initial begin
        int   pcnt;
        logic prev_sclk;
        pcnt = 17;
        prev_sclk = 1'b1;
        bus.data = '1;
        forever begin
            @(negedge clk);
            if (bus.latch) begin
                for (int p = 0; p < NP; p++) sent[p] = pad_line[p];
                pcnt = 0;
            end else if (bus.sclk && !prev_sclk && pcnt < 17) begin
                pcnt++;
            end
            prev_sclk = bus.sclk;
            for (int p = 0; p < NP; p++) bus.data[p] = (pcnt < 17) ? sent[p][pcnt] : 1'b1;
        end
    end

    // Reference model: tracks position inside a frame and the idle wait, checks every cycle.
    initial begin
        bit          m_in;
        bit          m_pend;
        int          m_k;
        int          m_idle;
        logic        e_latch, e_sclk, e_fv;
        logic [23:0] e_btn, e_prs, e_rel, nb;
        logic [1:0]  e_pres;
        m_in = 0; m_pend = 0; m_k = 0; m_idle = 0;
        e_btn = '0; e_pres = '0;
        forever begin
            @(posedge clk);
            e_prs = '0; e_rel = '0; e_fv = 1'b0;
            if (!res) begin
                m_in = 0; m_pend = 0; m_k = 0; m_idle = 0;
                e_btn = '0; e_pres = '0;
            end else if (m_in) begin
                if (bus.poll_req) m_pend = 1;
                m_k++;
                if (m_k == FL) begin
                    m_in = 0;
                    m_idle = 0;
                end
            end else if (!bus.enable) begin
                m_idle = 0;
                m_pend = 0;
            end else if (m_idle == PD - 1 || bus.poll_req || m_pend) begin
                m_in = 1; m_k = 0; m_pend = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
            e_latch = m_in && (m_k < LL);
            e_sclk  = !(m_in && m_k >= LL && m_k < LL + 34 * HB && (((m_k - LL) / HB) % 2) == 0);
            if (res && m_in && m_k == FL - 1) begin
                for (int p = 0; p < NP; p++) begin
                    nb[12*p +: 12] = model_pad(sent[p]);
                    e_pres[p]      = ~sent[p][16];
                end
                e_prs = nb & ~e_btn;
                e_rel = e_btn & ~nb;
                e_btn = nb;
                e_fv  = 1'b1;
            end
            #1;
            chk("m_latch",    bus.latch,       e_latch);
            chk("m_sclk",     bus.sclk,        e_sclk);
            chk("m_fvalid",   bus.frame_valid, e_fv);
            chk("m_buttons",  bus.buttons,     e_btn);
            chk("m_present",  bus.present,     e_pres);
            chk("m_pressed",  bus.pressed,     e_prs);
            chk("m_released", bus.released,    e_rel);
        end
    end

    task automatic wait_latch(input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (bus.latch) begin ok = 1; break; end
        end
        chk("wait_latch", ok, 1'b1);
    endtask

    task automatic wait_fv(input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (bus.frame_valid) begin ok = 1; break; end
        end
        chk("wait_fv", ok, 1'b1);
    endtask

    task automatic gap_to_latch(output int g);
        g = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            g++;
            if (bus.latch) break;
        end
    endtask

    // Starts on the first latch cycle, ends on the commit cycle.
    task automatic measure_frame(output int lat, output int lows, output int bad,
                                 output int highs, output int flen);
        logic prev;
        int   run;
        lat = 0; lows = 0; bad = 0; highs = 0; flen = 0; run = 0; prev = 1'b1;
        for (int i = 0; i < 400; i++) begin
            flen++;
            if (bus.latch) lat++;
            if (!bus.sclk) begin
                if (prev) lows++;
                run++;
            end else begin
                if (!prev && run != HB) bad++;
                run = 0;
                if (!bus.latch && !bus.frame_valid) highs++;
            end
            if (bus.frame_valid) break;
            prev = bus.sclk;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat, lows, bad, highs, flen, g, falls, lat_seen;
        logic prev;
        bus.enable   = 1'b0;
        bus.poll_req = 1'b0;
        pad_line[0]  = 17'h0FEFF;
        pad_line[1]  = 17'h1FFFF;
        res = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_latch",   bus.latch,       1'b0);
        chk("rst_sclk",    bus.sclk,        1'b1);
        chk("rst_buttons", bus.buttons,     24'h0);
        chk("rst_present", bus.present,     2'b00);
        chk("rst_fv",      bus.frame_valid, 1'b0);

        @(negedge clk);
        res = 1'b1;
        bus.enable = 1'b1;
        gap_to_latch(g);
        chk("first_poll_gap", g, PD);
        measure_frame(lat, lows, bad, highs, flen);
        chk("latch_len",   lat,   LL);
        chk("sclk_lows",   lows,  17);
        chk("low_widths",  bad,   0);
        chk("high_cycles", highs, 17 * HB);
        chk("frame_len",   flen,  107);
        chk("f1_buttons",  bus.buttons, 24'h000010);
        chk("f1_pressed",  bus.pressed, 24'h000010);
        chk("f1_present",  bus.present, 2'b01);
        @(posedge clk); #1;
        chk("f1_fv_off",   bus.frame_valid, 1'b0);
        chk("f1_prs_off",  bus.pressed, 24'h0);

        wait_fv(PD + FL + 10);
        chk("f2_pressed",  bus.pressed,  24'h0);
        chk("f2_released", bus.released, 24'h0);
        chk("f2_buttons",  bus.buttons,  24'h000010);
        pad_line[0] = 17'h0FFFF;
        wait_fv(PD + FL + 10);
        chk("f3_released", bus.released, 24'h000010);
        chk("f3_buttons",  bus.buttons,  24'h0);

        wait_latch(PD + 10);
        repeat (5) @(negedge clk);
        bus.poll_req = 1'b1;
        @(negedge clk);
        bus.poll_req = 1'b0;
        repeat (3) @(negedge clk);
        bus.poll_req = 1'b1;
        @(negedge clk);
        bus.poll_req = 1'b0;
        wait_fv(FL + 10);
        gap_to_latch(g);
        chk("pend_gap", g, 2);
        wait_fv(FL + 10);
        gap_to_latch(g);
        chk("auto_gap", g, PD + 1);

        wait_fv(FL + 10);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.poll_req = 1'b1;
        @(negedge clk);
        bus.poll_req = 1'b0;
        lat_seen = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (bus.latch) lat_seen++;
        end
        chk("disabled_no_frame", lat_seen, 0);

        pad_line[0] = 17'h0FEFF;
        @(negedge clk);
        bus.enable = 1'b1;
        wait_latch(PD + 10);
        falls = 0;
        prev = bus.sclk;
        for (int i = 0; i < 200 && falls < 10; i++) begin
            @(posedge clk); #1;
            if (!bus.sclk && prev) falls++;
            prev = bus.sclk;
        end
        @(negedge clk);
        res = 1'b0;
        #1;
        chk("abort_sclk",     bus.sclk,        1'b1);
        chk("abort_latch",    bus.latch,       1'b0);
        chk("abort_buttons",  bus.buttons,     24'h0);
        chk("abort_present",  bus.present,     2'b00);
        chk("abort_fv",       bus.frame_valid, 1'b0);
        repeat (3) @(negedge clk);
        res = 1'b1;
        gap_to_latch(g);
        chk("restart_gap", g, PD);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.poll_req = ($urandom_range(0, 59) == 0);
            if (!bus.enable && $urandom_range(0, 49) == 0)      bus.enable = 1'b1;
            else if (bus.enable && $urandom_range(0, 599) == 0) bus.enable = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 199) == 0) begin
                    if ($urandom_range(0, 3) == 0) pad_line[p] = {1'b1, 16'($urandom)};
                    else                           pad_line[p] = {1'b0, 16'($urandom)};
                end
            end
            if ($urandom_range(0, 1499) == 0) begin
                res = 1'b0;
                repeat (2) @(negedge clk);
                res = 1'b1;
            end
        end
        bus.poll_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/joypad_scanner.md
JOYPAD_SCANNER -- requirements
Module: joypad_scanner

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_PADS, default 2, number of serial pads sharing latch/sclk (1-4).
REQ-003 Parameter POLL_DIV, default 1372, clk cycles from frame end to next auto-poll (>=2).
REQ-004 Parameter HALF_BIT, default 1, clk cycles per sclk half-period (>=1).
REQ-005 Parameter LATCH_LEN, default 2, clk cycles latch is held high (>=1).
REQ-006 clk  in  1  system clock.
REQ-007 res  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  high permits auto-poll and poll_req.
REQ-009 poll_req  in  1  one-cycle request for an immediate poll.
REQ-010 data  in  NUM_PADS  serial data per pad, active-low buttons.
REQ-011 latch  out  1  pad latch strobe, registered, idle low.
REQ-012 sclk  out  1  shared serial clock, registered, idle high.
REQ-013 buttons  out  12*NUM_PADS  pressed state, active-high; pad p at [12p+11:12p].
REQ-014 pressed  out  12*NUM_PADS  one-cycle rising-edge events.
REQ-015 released  out  12*NUM_PADS  one-cycle falling-edge events.
REQ-016 present  out  NUM_PADS  pad-connected flag per pad.
REQ-017 frame_valid  out  1  one-cycle pulse when outputs update.

Function
REQ-018 SHALL implement states IDLE, LATCH, LOW, HIGH, COMMIT.
REQ-019 IDLE: poll counter increments while enable=1; on reaching POLL_DIV-1, or on poll_req/pending request with enable=1, SHALL enter LATCH with counter cleared.
REQ-020 enable=0 in IDLE SHALL hold counter at 0 and clear any pending request; a frame in progress SHALL complete normally.
REQ-021 poll_req outside IDLE SHALL set a single pending flag, serviced on next IDLE cycle; further requests while pending SHALL be dropped.
REQ-022 LATCH: latch=1 for exactly LATCH_LEN cycles, sclk=1, then LOW with bit index 0.
REQ-023 LOW: sclk=0 for HALF_BIT cycles; on the last LOW cycle, data[p] SHALL be sampled into shift bit[index] for every pad in parallel.
REQ-024 HIGH: sclk=1 for HALF_BIT cycles; then index+1 and LOW, or COMMIT after index 16 (17 bits total per frame).
REQ-025 Sampled bits SHALL be stored inverted (line low = 1) for bits 0-15; bit 16 stored raw.
REQ-026 present[p] SHALL be 1 iff raw bit 16 of pad p is 0 (connected pad drives low after 16 bits; pulled-up open line reads 1).
REQ-027 Button mapping, output bit <- serial bit: 0 up<-4, 1 down<-5, 2 left<-6, 3 right<-7, 4 A<-8, 5 B<-0, 6 X<-9, 7 Y<-1, 8 L<-10, 9 R<-11, 10 select<-2, 11 start<-3; serial bits 12-15 discarded.
REQ-028 Absent pad (present=0) SHALL report buttons=0 for that pad.
REQ-029 COMMIT (one cycle): buttons, present updated; pressed=new&~old, released=old&~new; frame_valid=1; next state IDLE.
REQ-030 pressed, released, frame_valid SHALL be 0 in every cycle except the COMMIT cycle.
REQ-031 Pad removal SHALL produce released pulses for all previously held buttons of that pad.
REQ-032 Frame length SHALL be LATCH_LEN + 34*HALF_BIT + 1 cycles from LATCH entry to COMMIT inclusive.
REQ-033 latch and sclk SHALL be driven from flops only; clk SHALL NOT be gated to outputs.

Reset
REQ-034 Reset assertion SHALL asynchronously force state IDLE, counter 0, pending 0, latch 0, sclk 1, buttons 0, pressed 0, released 0, present 0, frame_valid 0.
REQ-035 Reset mid-frame SHALL abort the frame with no COMMIT; first poll after release SHALL occur POLL_DIV cycles later or on poll_req.

Verification
REQ-036 Defaults, pad 0 model holding A (serial bit 8 low), bit 16 low -> after first COMMIT buttons[4]=1, pressed[4]=1, present[0]=1, frame_valid one cycle.
REQ-037 Pad 1 data tied high -> present[1]=0, buttons[23:12]=0 every frame.
REQ-038 HALF_BIT=3, LATCH_LEN=4: measure latch high 4 cycles, sclk 17 low/high pulses of 3 cycles each, frame 107 cycles.
REQ-039 A held two frames then released -> pressed[4] only on frame 1, no event frame 2, released[4] on frame 3.
REQ-040 poll_req twice during active frame -> exactly one extra frame begins the cycle after COMMIT; enable=0 then poll_req -> no frame.
REQ-041 res low at bit index 9 -> sclk=1, latch=0, all outputs 0 immediately; no frame_valid until next poll.
